// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART instruction-memory loader:
//   - frame FSM state encodings (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR)
//   - SYNC_BYTE, the frame start marker
//   - clks_per_bit(): bit period in clock cycles for a given clock/baud pair
//   - chk_update(): running XOR used by the optional frame checksum
// ----------------------------------------------------------------------------
package loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Integer division: the receiver tolerates the truncation error.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
// UART 8N1 byte receiver: 2-flop synchronizer, falling-edge start detection,
// start-bit re-check at half a bit, LSB-first mid-bit sampling, stop check.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   uart_rx      serial input, idle high, asynchronous to clk
//   byte_valid   one-cycle pulse, one cycle after a good stop-bit sample
//   byte_data    received byte, stable while byte_valid is high
//   frame_err    one-cycle pulse, one cycle after a stop bit sampled low
// ----------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic [1:0]       rx_state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             byte_valid_r;
    logic             frame_err_r;

    // Synchronizer, bit timer, sampling FSM and result strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            rx_state_r   <= RX_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_meta_r    <= uart_rx;
            rx_sync_r    <= rx_meta_r;
            rx_prev_r    <= rx_sync_r;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    // Edge rather than level, so a line stuck low after a
                    // framing error does not retrigger reception.
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r <= '0;
                        // Line back high at mid start bit: glitch, drop it.
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r   <= '0;
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r        <= '0;
                        byte_valid_r <= rx_sync_r;
                        frame_err_r  <= !rx_sync_r;
                        rx_state_r   <= RX_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    assign byte_valid = byte_valid_r;
    assign byte_data  = shift_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/imem_uart_loader.sv
// ----------------------------------------------------------------------------
// imem_uart_loader
// Serial program loader: receives SYNC, LEN_LO, LEN_HI, 4*LEN data bytes
// (little-endian words) and, when built with LOADER_CHECKSUM_EN, a trailing
// XOR checksum byte. Words are written to instruction memory through a
// dedicated write port while the core is held in reset.
// Build option: `define LOADER_CHECKSUM_EN to require and verify the CHK byte.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   uart_rx      serial input (8N1, idle high)
//   imem_we      one-cycle write strobe
//   imem_waddr   word address of the write
//   imem_wdata   assembled 32-bit word
//   core_hold    core reset, high while a load is active or after an abort
//   busy         frame reception in progress
//   done         last frame completed (sticky)
//   error        last frame aborted (sticky)
// ----------------------------------------------------------------------------
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int          CPB      = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

    logic              rx_valid_s;
    logic [7:0]        rx_data_s;
    logic              rx_ferr_s;

    logic [2:0]        state_r;
    logic [7:0]        len_lo_r;
    logic [ADDR_W-1:0] len_m1_r;
    logic [1:0]        byte_cnt_r;
    logic              last_word_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [31:0]       wdata_r;
    logic              core_hold_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;

    logic              sync_accept_s;
    logic              data_byte_s;
    logic              active_s;
    logic              len_ok_s;
    logic [15:0]       len_s;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .byte_valid(rx_valid_s),
        .byte_data (rx_data_s),
        .frame_err (rx_ferr_s)
    );

    // Byte classification against the current frame state.
    always_comb begin
        sync_accept_s = 1'b0;
        data_byte_s   = 1'b0;
        active_s      = 1'b0;
        len_s         = {rx_data_s, len_lo_r};
        len_ok_s      = (len_s != 16'd0) && ({1'b0, len_s} <= CAPACITY);
        if (rx_valid_s && (rx_data_s == SYNC_BYTE) &&
            ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR))) begin
            sync_accept_s = 1'b1;
        end else begin
            sync_accept_s = 1'b0;
        end
        if (rx_valid_s && (state_r == ST_DATA)) begin
            data_byte_s = 1'b1;
        end else begin
            data_byte_s = 1'b0;
        end
        case (state_r)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: active_s = 1'b1;
            default:                                 active_s = 1'b0;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_r;

    // Running XOR of the data bytes of the current frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_r <= 8'h00;
        end else if (sync_accept_s) begin
            chk_r <= 8'h00;
        end else if (data_byte_s) begin
            chk_r <= chk_update(chk_r, rx_data_s);
        end else begin
            chk_r <= chk_r;
        end
    end
`endif

    // Frame FSM, word assembly, address counter and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            len_lo_r    <= 8'h00;
            len_m1_r    <= '0;
            byte_cnt_r  <= 2'd0;
            last_word_r <= 1'b0;
            imem_we_r   <= 1'b0;
            waddr_r     <= '0;
            wdata_r     <= 32'h0000_0000;
            core_hold_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            if (rx_ferr_s && active_s) begin
                // core_hold intentionally left high: a partial image must not run.
                state_r <= ST_ERROR;
                busy_r  <= 1'b0;
                error_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (sync_accept_s) begin
                            state_r     <= ST_LEN_LO;
                            core_hold_r <= 1'b1;
                            busy_r      <= 1'b1;
                            done_r      <= 1'b0;
                            error_r     <= 1'b0;
                            waddr_r     <= '0;
                            byte_cnt_r  <= 2'd0;
                            last_word_r <= 1'b0;
                        end
                    end
                    ST_LEN_LO: begin
                        if (rx_valid_s) begin
                            len_lo_r <= rx_data_s;
                            state_r  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (rx_valid_s) begin
                            if (len_ok_s) begin
                                len_m1_r <= ADDR_W'(len_s - 16'd1);
                                state_r  <= ST_DATA;
                            end else begin
                                state_r <= ST_ERROR;
                                busy_r  <= 1'b0;
                                error_r <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (data_byte_s) begin
                            wdata_r    <= {rx_data_s, wdata_r[31:8]};
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            if (byte_cnt_r == 2'd3) begin
                                imem_we_r   <= 1'b1;
                                last_word_r <= (waddr_r == len_m1_r);
                            end
                        end else if (imem_we_r) begin
                            // Cycle after the strobe: advance, or close the frame.
                            // The last word never increments, so waddr cannot wrap.
                            if (last_word_r) begin
`ifdef LOADER_CHECKSUM_EN
                                state_r <= ST_CHECK;
`else
                                state_r     <= ST_DONE;
                                core_hold_r <= 1'b0;
                                busy_r      <= 1'b0;
                                done_r      <= 1'b1;
`endif
                            end else begin
                                waddr_r <= waddr_r + ADDR_W'(1);
                            end
                        end
                    end
                    ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                        if (rx_valid_s) begin
                            busy_r <= 1'b0;
                            if (rx_data_s == chk_r) begin
                                state_r     <= ST_DONE;
                                core_hold_r <= 1'b0;
                                done_r      <= 1'b1;
                            end else begin
                                state_r <= ST_ERROR;
                                error_r <= 1'b1;
                            end
                        end
`else
                        state_r <= ST_ERROR;
                        busy_r  <= 1'b0;
                        error_r <= 1'b1;
`endif
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign imem_we    = imem_we_r;
    assign imem_waddr = waddr_r;
    assign imem_wdata = wdata_r;
    assign core_hold  = core_hold_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_imem_uart_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_uart_loader
// Directed bench for imem_uart_loader. The bit period is shortened to 40
// clocks so the whole scenario list stays short; the glitch width is scaled
// accordingly (below half a bit). Handles both checksum build options.
// ----------------------------------------------------------------------------
module tb_imem_uart_loader;

    localparam int CLK_HZ = 4_608_000;
    localparam int BAUD   = 115200;
    localparam int CPB    = 40;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              uart_rx = 1'b1;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    int           cyc = 0;
    logic [7:0]   wr_addr_q[$];
    logic [31:0]  wr_data_q[$];
    int           last_we_cyc = -1;
    int           last_valid_cyc = -1;
    int           done_rise_cyc = -1;
    int           hold_fall_cyc = -1;
    int           valid_cnt = 0;
    logic         hold_at_we = 1'b0;
    logic         done_q = 1'b0;
    logic         hold_q = 1'b0;

    logic [7:0]   frame_q[$];
    int           base;
    int           vbase;

    imem_uart_loader #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD       (BAUD),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and timing monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_waddr);
            wr_data_q.push_back(imem_wdata);
            last_we_cyc = cyc;
            hold_at_we  = core_hold;
        end
        if (dut.rx_valid_s) begin
            last_valid_cyc = cyc;
            valid_cnt      = valid_cnt + 1;
        end
        if (done && !done_q) done_rise_cyc = cyc;
        if (!core_hold && hold_q) hold_fall_cyc = cyc;
        done_q = done;
        hold_q = core_hold;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame_q();
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], 1'b1);
        end
        idle(2 * CPB);
    endtask

    // Reference frame: two words, 0x00000013 and 0x00100093; optionally a
    // corrupted checksum (chk ^ 1).
    task automatic build_frame(input logic bad_chk);
        logic [31:0] w [2];
        logic [7:0]  chk;
        w[0] = 32'h0000_0013;
        w[1] = 32'h0010_0093;
        chk  = 8'h00;
        frame_q = {8'hA5, 8'h02, 8'h00};
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                frame_q.push_back(w[k][8*j +: 8]);
                chk = chk ^ w[k][8*j +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        frame_q.push_back(bad_chk ? (chk ^ 8'h01) : chk);
`else
        if (bad_chk) frame_q.push_back(8'h00);
`endif
    endtask

    task automatic check_good_load(input string tag);
        check_eq({tag, "_nwr"}, wr_addr_q.size() - base, 2);
        if (wr_addr_q.size() - base == 2) begin
            check_eq({tag, "_a0"}, {24'h0, wr_addr_q[base]}, 32'd0);
            check_eq({tag, "_d0"}, wr_data_q[base], 32'h0000_0013);
            check_eq({tag, "_a1"}, {24'h0, wr_addr_q[base+1]}, 32'd1);
            check_eq({tag, "_d1"}, wr_data_q[base+1], 32'h0010_0093);
        end
        check_eq({tag, "_hold_at_we"}, {31'h0, hold_at_we}, 32'd1);
        check_eq({tag, "_done"}, {31'h0, done}, 32'd1);
        check_eq({tag, "_error"}, {31'h0, error}, 32'd0);
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check_eq({tag, "_hold"}, {31'h0, core_hold}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check_eq({tag, "_hold_fall_lat"}, hold_fall_cyc - last_valid_cyc, 32'd1);
`else
        check_eq({tag, "_hold_fall_lat"}, hold_fall_cyc - last_we_cyc, 32'd1);
        check_eq({tag, "_done_lat"}, done_rise_cyc - last_we_cyc, 32'd1);
`endif
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_we",    {31'h0, imem_we}, 32'd0);
        check_eq("rst_waddr", {24'h0, imem_waddr}, 32'd0);
        check_eq("rst_wdata", imem_wdata, 32'd0);
        check_eq("rst_hold",  {31'h0, core_hold}, 32'd0);
        check_eq("rst_busy",  {31'h0, busy}, 32'd0);
        check_eq("rst_done",  {31'h0, done}, 32'd0);
        check_eq("rst_error", {31'h0, error}, 32'd0);
        reset = 1'b0;
        idle(20);

        // Short low glitch on an idle line.
        vbase = valid_cnt;
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        idle(3 * CPB);
        check_eq("glitch_valid", valid_cnt - vbase, 32'd0);
        check_eq("glitch_busy", {31'h0, busy}, 32'd0);

        // Garbage, then a good frame.
        base = wr_addr_q.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(CPB);
        check_eq("garbage_busy", {31'h0, busy}, 32'd0);
        build_frame(1'b0);
        send_frame_q();
        check_good_load("good");

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum, then recovery with the correct frame.
        base = wr_addr_q.size();
        build_frame(1'b1);
        send_frame_q();
        check_eq("badchk_nwr",   wr_addr_q.size() - base, 32'd2);
        check_eq("badchk_error", {31'h0, error}, 32'd1);
        check_eq("badchk_done",  {31'h0, done}, 32'd0);
        check_eq("badchk_hold",  {31'h0, core_hold}, 32'd1);
        base = wr_addr_q.size();
        hold_fall_cyc = -1;
        build_frame(1'b0);
        send_frame_q();
        check_good_load("resend");
`endif

        // LEN = 0.
        base = wr_addr_q.size();
        frame_q = {8'hA5, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_frame_q();
        check_eq("len0_error", {31'h0, error}, 32'd1);
        check_eq("len0_busy",  {31'h0, busy}, 32'd0);
        check_eq("len0_hold",  {31'h0, core_hold}, 32'd1);
        check_eq("len0_nwr",   wr_addr_q.size() - base, 32'd0);

        // LEN = 0x0101 exceeds 256 words.
        frame_q = {8'hA5, 8'h01, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
        send_frame_q();
        check_eq("len257_error", {31'h0, error}, 32'd1);
        check_eq("len257_nwr",   wr_addr_q.size() - base, 32'd0);

        // Stop bit low on the 3rd data byte.
        frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b1);
        check_eq("ferr_busy_before", {31'h0, busy}, 32'd1);
        send_byte(8'h00, 1'b0);
        idle(2 * CPB);
        check_eq("ferr_error", {31'h0, error}, 32'd1);
        check_eq("ferr_busy",  {31'h0, busy}, 32'd0);
        check_eq("ferr_hold",  {31'h0, core_hold}, 32'd1);
        check_eq("ferr_nwr",   wr_addr_q.size() - base, 32'd0);

        // Reset in the middle of word 1.
        frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b1);
        check_eq("midrst_pre_waddr", {24'h0, imem_waddr}, 32'd1);
        check_eq("midrst_pre_hold",  {31'h0, core_hold}, 32'd1);
        base = wr_addr_q.size();
        reset = 1'b1;
        #1;
        check_eq("midrst_we",    {31'h0, imem_we}, 32'd0);
        check_eq("midrst_waddr", {24'h0, imem_waddr}, 32'd0);
        check_eq("midrst_wdata", imem_wdata, 32'd0);
        check_eq("midrst_hold",  {31'h0, core_hold}, 32'd0);
        check_eq("midrst_busy",  {31'h0, busy}, 32'd0);
        check_eq("midrst_done",  {31'h0, done}, 32'd0);
        check_eq("midrst_error", {31'h0, error}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        frame_q = {8'h10, 8'h00, 8'h90};
        send_frame_q();
        check_eq("midrst_nwr",  wr_addr_q.size() - base, 32'd0);
        check_eq("midrst_hold_after", {31'h0, core_hold}, 32'd0);
        check_eq("midrst_done_after", {31'h0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
